// File: rtl/io_bus_master.sv
// CPU-side master for the memory-mapped IO bus: decodes the device index, drives addr/ctrl/data and one-hot BG.
// Optional SETUP phase: define IO_BUS_SETUP_EN. dbg_state encoding: 0 IDLE, 1 SETUP, 2 XFER, 3 RESP.

`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_CTRL_WE
`define IO_BUS_CTRL_WE 0
`endif
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif

module io_bus_master #(
  parameter int DEV_NUM    = 4,
  parameter int DEV_SEL_HI = 15,
  parameter int DEV_SEL_LO = 12,
  parameter int XFER_CYC   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [`IO_BUS_WIDTH_ADDR-1:0] cpu_addr,
  input  logic [`IO_BUS_WIDTH_DATA-1:0] cpu_wdata,
  output logic [`IO_BUS_WIDTH_DATA-1:0] cpu_rdata,
  output logic                          cpu_ready,
  output logic                          cpu_err,
  output logic [DEV_NUM-1:0]            bg,
  output logic [`IO_BUS_WIDTH_ADDR-1:0] addr,
  output logic [`IO_BUS_WIDTH_CTRL-1:0] ctrl,
  inout  wire  [`IO_BUS_WIDTH_DATA-1:0] data,
  output logic [1:0]                    dbg_state
);

  localparam int IDX_W = DEV_SEL_HI - DEV_SEL_LO + 1;
  localparam logic [3:0] LAST_CNT = 4'(XFER_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_we;
  logic [`IO_BUS_WIDTH_ADDR-1:0] r_addr;
  logic [`IO_BUS_WIDTH_DATA-1:0] r_wdata;
  logic [`IO_BUS_WIDTH_DATA-1:0] r_rdata;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_err;
  logic [3:0]                    r_cnt;

  logic [IDX_W-1:0]              w_idx;
  logic                          w_unmapped;
  logic                          w_accept;
  logic                          w_xfer_last;
  logic                          w_drive;

  assign w_idx       = cpu_addr[DEV_SEL_HI:DEV_SEL_LO];
  assign w_unmapped  = (int'(w_idx) >= DEV_NUM);
  assign w_accept    = (r_state == S_IDLE) && cpu_req;
  assign w_xfer_last = (r_cnt == LAST_CNT);
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= cpu_we;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_idx   <= w_idx;
        r_err   <= w_unmapped;
        r_rdata <= '0;
        r_cnt   <= '0;
      end
      // Load data is taken at the edge closing the last BG cycle.
      if (r_state == S_XFER) begin
        if (w_xfer_last) begin
          r_cnt <= '0;
          if (!r_we) r_rdata <= data;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          if (w_unmapped) w_next = S_RESP;
`ifdef IO_BUS_SETUP_EN
          else            w_next = S_SETUP;
`else
          else            w_next = S_XFER;
`endif
        end
      end
      S_SETUP: w_next = S_XFER;
      S_XFER:  if (w_xfer_last) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bg        = '0;
    addr      = '0;
    ctrl      = '0;
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = '0;
    for (int i = 0; i < DEV_NUM; i++) begin
      bg[i] = (r_state == S_XFER) && (int'(r_idx) == i);
    end
    if (r_state != S_IDLE) begin
      addr                  = r_addr;
      ctrl[`IO_BUS_CTRL_WE] = r_we ? `IO_CTRL_WRITE : `IO_CTRL_READ;
    end
    if (r_state == S_RESP) begin
      cpu_ready = 1'b1;
      cpu_err   = r_err;
      cpu_rdata = r_rdata;
    end
  end

  // The master owns the data lines only while granting a store, so release coincides with BG falling.
  assign w_drive = (r_state == S_XFER) && r_we;
  assign data    = w_drive ? r_wdata : 'z;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: random load/store traffic against simple peripheral models and a reference model.
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_CTRL_WE
`define IO_BUS_CTRL_WE 0
`endif
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif

module tb_io_bus_master;
  localparam int DEV_NUM  = 4;
  localparam int XFER_CYC = 3;
  localparam int AW = `IO_BUS_WIDTH_ADDR;
  localparam int DW = `IO_BUS_WIDTH_DATA;
  localparam int CW = `IO_BUS_WIDTH_CTRL;
`ifdef IO_BUS_SETUP_EN
  localparam int SETUP_CYC = 1;
`else
  localparam int SETUP_CYC = 0;
`endif

  typedef struct packed {
    int                 cyc;
    logic [DEV_NUM-1:0] bg;
    logic [CW-1:0]      ctrl;
    logic               err;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      addr;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  wire  [DW-1:0] cpu_rdata;
  wire           cpu_ready;
  wire           cpu_err;
  wire  [DEV_NUM-1:0] bg;
  wire  [AW-1:0] addr;
  wire  [CW-1:0] ctrl;
  wire  [DW-1:0] data;
  wire  [1:0]    dbg_state;

  io_bus_master #(
    .DEV_NUM(DEV_NUM), .DEV_SEL_HI(15), .DEV_SEL_LO(12), .XFER_CYC(XFER_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .bg(bg), .addr(addr),
    .ctrl(ctrl), .data(data), .dbg_state(dbg_state)
  );

  // Peripheral models: register per device; read data steps by one each BG cycle so the sample point is visible.
  logic [DW-1:0] dev_reg [DEV_NUM];
  int            rd_cyc = 0;
  logic          per_drv;
  logic [DW-1:0] per_val;
  always_comb begin
    per_drv = 1'b0;
    per_val = '0;
    for (int i = 0; i < DEV_NUM; i++) begin
      if (bg[i] && ctrl[`IO_BUS_CTRL_WE] == `IO_CTRL_READ) begin
        per_drv = 1'b1;
        per_val = dev_reg[i] + DW'(rd_cyc);
      end
    end
  end
  assign data = per_drv ? per_val : 'z;
  always @(posedge clk) begin
    if (bg != '0 && ctrl[`IO_BUS_CTRL_WE] == `IO_CTRL_READ) rd_cyc <= rd_cyc + 1;
    else rd_cyc <= 0;
    for (int i = 0; i < DEV_NUM; i++)
      if (bg[i] && ctrl[`IO_BUS_CTRL_WE] == `IO_CTRL_WRITE) dev_reg[i] <= data;
  end

  // scoreboard
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [DW-1:0] ref_reg [DEV_NUM];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: transaction-level effect of one request accepted at edge 'acc'.
  task automatic predict(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int acc, output exp_t e);
    logic [3:0] idx4;
    int idx;
    idx4 = a[15:12];
    idx  = int'(idx4);
    e = '0;
    e.addr = a;
    e.ctrl[`IO_BUS_CTRL_WE] = we ? `IO_CTRL_WRITE : `IO_CTRL_READ;
    if (idx >= DEV_NUM) begin
      e.err = 1'b1;
      e.cyc = acc;
    end else begin
      e.bg  = DEV_NUM'(1) << idx;
      e.cyc = acc + SETUP_CYC + XFER_CYC;
      if (we) ref_reg[idx] = wd;
      else    e.rdata = ref_reg[idx] + DW'(XFER_CYC - 1);
    end
  endtask

  // monitor
  int                 bg_cnt = 0;
  logic [DEV_NUM-1:0] bg_seen = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bg_cnt  = 0;
      bg_seen = '0;
    end else begin
      if (bg != '0) begin
        bg_cnt++;
        bg_seen = bg;
        chk("bg_onehot", $countones(bg), 1);
      end
      if (cpu_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ready_cycle", cyc, e.cyc);
          chk("cpu_err", cpu_err, e.err);
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("bg_value", bg_seen, e.bg);
          chk("bg_cycles", bg_cnt, e.err ? 0 : XFER_CYC);
          if (!e.err) begin
            chk("addr", addr, e.addr);
            chk("ctrl", ctrl, e.ctrl);
          end
        end
        bg_cnt  = 0;
        bg_seen = '0;
      end
    end
  end

  // driver tasks
  task automatic wait_done();
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    if (n == 60) begin
      chk("completion_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic single(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    exp_t e;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    predict(we, a, wd, cyc, e);
    exp_q.push_back(e);
    wait_done();
  endtask

  task automatic b2b(input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] wd1,
                     input logic we2, input logic [AW-1:0] a2, input logic [DW-1:0] wd2);
    exp_t e1, e2;
    int n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we1; cpu_addr = a1; cpu_wdata = wd1;
    @(posedge clk); #1;
    predict(we1, a1, wd1, cyc, e1);
    exp_q.push_back(e1);
    cpu_we = we2; cpu_addr = a2; cpu_wdata = wd2;
    // Second request is taken at the edge closing the IDLE cycle that follows RESP.
    predict(we2, a2, wd2, e1.cyc + 2, e2);
    exp_q.push_back(e2);
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cpu_ready) break;
    end
    if (n == 60) chk("b2b_first_timeout", 1, 0);
    @(posedge clk);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    wait_done();
  endtask

  task automatic reset_abort(input int idx, input logic [DW-1:0] wd);
    logic [AW-1:0] a;
    int n;
    a = $urandom;
    a[15:12] = 4'(idx);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bg != '0) break;
    end
    if (n == 20) chk("abort_reach_xfer", 1, 0);
    chk("abort_store_data", data, wd);
    rst = 1'b1;
    // The peripheral still captures at the edge ending the first BG cycle.
    ref_reg[idx] = wd;
    @(negedge clk);
    chk("abort_bg", bg, 0);
    chk("abort_ready", cpu_ready, 0);
    chk("abort_state_idle", dbg_state, 0);
    chk("abort_addr", addr, 0);
    @(negedge clk);
    chk("abort_ready_2", cpu_ready, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_no_ready", cpu_ready, 0);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input int idx);
    logic [AW-1:0] a;
    a = $urandom;
    a[15:12] = 4'(idx);
    return a;
  endfunction

  initial begin
    for (int i = 0; i < DEV_NUM; i++) begin
      logic [DW-1:0] r;
      r = $urandom;
      dev_reg[i] <= r;
      ref_reg[i] = r;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_bg", bg, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;

    single(1'b1, 32'h0000_0010, 32'h0000_00A5);
    chk("led_value", dev_reg[0], 32'h0000_00A5);
    single(1'b1, 32'h0000_2004, 32'h0000_003C);
    single(1'b0, 32'h0000_2004, 32'h0);
    single(1'b0, 32'h0000_0010, 32'h0);
    single(1'b0, 32'h0000_7010, 32'h0);
    single(1'b1, 32'h0000_F000, 32'hDEAD_BEEF);
    b2b(1'b1, 32'h0000_3008, 32'h1234_5678, 1'b0, 32'h0000_3008, 32'h0);

    reset_abort(1, 32'h5555_AAAA);
    single(1'b0, mk_addr(1), 32'h0);

    for (int k = 0; k < 40; k++)
      single(1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 7)), $urandom);
    for (int k = 0; k < 6; k++)
      b2b(1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 5)), $urandom,
          1'($urandom_range(0, 1)), mk_addr($urandom_range(0, 5)), $urandom);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
